axi4_read_id_arbiter: RTL
=========================

Name: axi4_read_id_arbiter

Overview:
- Shares one AXI4 read master port (AR/R) between N upstream read requesters.
- Widens the ID on the way down: {source index, requester ID}.
- Routes R beats back to the originating requester using the upper ID bits.
- Caps outstanding bursts per requester. Sits upstream of the ID indexer, which may then fold the added high ID bits into echo.

Parameters:
- N, 4, number of requesters; power of two, 2..8; SRC_W = log2(N)
- IN_ID_W, 4, requester ID width; OUT_ID_W = IN_ID_W + SRC_W
- ADDR_W, 32, address width
- DATA_W, 64, R data width
- MAX_OUTSTANDING, 8, max in-flight read bursts per requester; counter width CNT_W = clog2(MAX_OUTSTANDING+1)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- in_ar_valid  in  N  per-requester AR valid
- in_ar_ready  out  N  per-requester AR ready
- in_ar_bits_id  in  N*IN_ID_W  packed, requester i at slice i
- in_ar_bits_addr  in  N*ADDR_W  packed
- in_ar_bits_len  in  N*8  packed
- in_ar_bits_size  in  N*3  packed
- in_ar_bits_burst  in  N*2  packed
- in_r_valid  out  N  per-requester R valid
- in_r_ready  in  N  per-requester R ready
- in_r_bits_id  out  IN_ID_W  low IN_ID_W bits of out_r_bits_id, broadcast
- in_r_bits_data  out  DATA_W  broadcast
- in_r_bits_resp  out  2  broadcast
- in_r_bits_last  out  1  broadcast
- out_ar_valid / out_ar_ready  out / in  1  downstream AR handshake
- out_ar_bits_id  out  OUT_ID_W  {grant index, requester ID}
- out_ar_bits_addr/len/size/burst  out  ADDR_W/8/3/2  muxed from the granted requester
- out_r_valid / out_r_ready  in / out  1  downstream R handshake
- out_r_bits_id/data/resp/last  in  OUT_ID_W/DATA_W/2/1  downstream R payload
- busy  out  1  any outstanding counter nonzero
- err_unexpected_r  out  1  sticky: R last seen for a source whose counter is 0

Behaviour:
- Reset: all counters = 0, rr_ptr = 0, locked = 0, err_unexpected_r = 0. While reset is high:
  - out_ar_valid, out_r_ready, in_ar_ready and in_r_valid are forced to 0.
  - busy = 0.
- Eligibility: eligible[i] = in_ar_valid[i] && cnt[i] < MAX_OUTSTANDING.
- Selection when unlocked: round-robin. Pick the first eligible index scanning rr_ptr, rr_ptr+1, ... mod N. The selection is combinational, giving 0-cycle latency.
- Selection when locked: sel = lock_idx, regardless of eligibility. This meets the AXI rule that valid and payload stay stable until accepted.
- AR output:
  - out_ar_valid = locked || any(eligible).
  - Payload is muxed from sel; out_ar_bits_id = {sel[SRC_W-1:0], in_ar_bits_id[sel]}.
  - in_ar_ready[i] = out_ar_ready && out_ar_valid && sel == i; all other lanes are 0.
- Lock state machine:
  - UNLOCKED -> LOCKED when out_ar_valid && !out_ar_ready; lock_idx <= sel.
  - LOCKED -> UNLOCKED on out_ar_ready.
  - Any AR fire: rr_ptr <= (sel+1) mod N, cnt[sel] += 1.
- R routing:
  - src = out_r_bits_id[OUT_ID_W-1 -: SRC_W].
  - in_r_valid[i] = out_r_valid && src == i.
  - out_r_ready = in_r_ready[src].
  - Payload is broadcast; the ID is stripped to its low IN_ID_W bits.
- On an R fire with last = 1:
  - If cnt[src] > 0, decrement it.
  - If cnt[src] == 0, the counter holds at 0 and err_unexpected_r <= 1, cleared only by reset.
  - Non-last beats do not touch the counters.
- Simultaneous AR fire and R last fire on the same source: counter unchanged (net zero). On different sources, both updates apply in the same cycle.
- Counter at MAX: the requester is ineligible, so it is never newly granted, and the counter cannot overflow. A locked grant was already counted as eligible when taken, so the limit holds.
- busy is registered-derived: OR of (cnt[i] != 0) from the current counter state.
- Reset asserted mid-burst: all state is discarded. A downstream response arriving after reset sets err_unexpected_r, which is acceptable and documented.

Test Plan:
- Single requester 2, ID 0x5, addr 0x8000_0040, len 3, out_ar_ready = 1 -> out_ar_bits_id = 0x25 the same cycle, cnt[2] = 1, busy = 1. Then 4 R beats with id 0x25 (last on beat 4) -> in_r_valid[2] only, in_r_bits_id = 0x5, cnt[2] = 0, busy = 0.
- All 4 requesters valid continuously, out_ar_ready = 1 -> grant order 0,1,2,3,0,... One grant per cycle, rr_ptr wrapping 3 -> 0.
- Requester 1 valid, out_ar_ready held low 3 cycles, then requester 0 asserts valid -> out_ar_valid stays 1 and id/addr stay on requester 1 until ready. Requester 1 fires first, then requester 0 next cycle.
- Requester 3 issues 8 ARs with no R returned -> 9th request is never granted and in_ar_ready[3] stays 0. One R last for source 3 -> cnt[3] = 7 and the 9th AR fires the next cycle.
- In the same cycle, AR fire from requester 0 and R last for source 0 with cnt[0] = 2 -> cnt[0] stays 2. With R last for source 1 instead -> cnt[0] = 3, cnt[1] decremented.
- R last with id 0x31 while cnt[3] = 0 -> err_unexpected_r = 1 next cycle and remains 1. Assert reset for 1 cycle -> err_unexpected_r = 0, all counters 0, out_ar_valid = 0 during reset.

Source files
------------

// File: rtl/axi4_read_id_arbiter_if.sv
// AXI4 read bus bundle for the read ID arbiter.
// Holds the N upstream requester lanes and the shared downstream port.
interface axi4_read_id_arbiter_if #(
    parameter int N       = 4,
    parameter int IN_ID_W = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
);
    localparam int SRC_W    = $clog2(N);
    localparam int OUT_ID_W = IN_ID_W + SRC_W;

    logic [N-1:0]         in_ar_valid;
    logic [N-1:0]         in_ar_ready;
    logic [N*IN_ID_W-1:0] in_ar_bits_id;
    logic [N*ADDR_W-1:0]  in_ar_bits_addr;
    logic [N*8-1:0]       in_ar_bits_len;
    logic [N*3-1:0]       in_ar_bits_size;
    logic [N*2-1:0]       in_ar_bits_burst;
    logic [N-1:0]         in_r_valid;
    logic [N-1:0]         in_r_ready;
    logic [IN_ID_W-1:0]   in_r_bits_id;
    logic [DATA_W-1:0]    in_r_bits_data;
    logic [1:0]           in_r_bits_resp;
    logic                 in_r_bits_last;

    logic                 out_ar_valid;
    logic                 out_ar_ready;
    logic [OUT_ID_W-1:0]  out_ar_bits_id;
    logic [ADDR_W-1:0]    out_ar_bits_addr;
    logic [7:0]           out_ar_bits_len;
    logic [2:0]           out_ar_bits_size;
    logic [1:0]           out_ar_bits_burst;
    logic                 out_r_valid;
    logic                 out_r_ready;
    logic [OUT_ID_W-1:0]  out_r_bits_id;
    logic [DATA_W-1:0]    out_r_bits_data;
    logic [1:0]           out_r_bits_resp;
    logic                 out_r_bits_last;

    modport slave (
        input  in_ar_valid, in_ar_bits_id, in_ar_bits_addr,
        input  in_ar_bits_len, in_ar_bits_size, in_ar_bits_burst,
        output in_ar_ready,
        output in_r_valid, in_r_bits_id, in_r_bits_data,
        output in_r_bits_resp, in_r_bits_last,
        input  in_r_ready,
        output out_ar_valid, out_ar_bits_id, out_ar_bits_addr,
        output out_ar_bits_len, out_ar_bits_size, out_ar_bits_burst,
        input  out_ar_ready,
        input  out_r_valid, out_r_bits_id, out_r_bits_data,
        input  out_r_bits_resp, out_r_bits_last,
        output out_r_ready
    );

    modport master (
        output in_ar_valid, in_ar_bits_id, in_ar_bits_addr,
        output in_ar_bits_len, in_ar_bits_size, in_ar_bits_burst,
        input  in_ar_ready,
        input  in_r_valid, in_r_bits_id, in_r_bits_data,
        input  in_r_bits_resp, in_r_bits_last,
        output in_r_ready,
        input  out_ar_valid, out_ar_bits_id, out_ar_bits_addr,
        input  out_ar_bits_len, out_ar_bits_size, out_ar_bits_burst,
        output out_ar_ready,
        output out_r_valid, out_r_bits_id, out_r_bits_data,
        output out_r_bits_resp, out_r_bits_last,
        input  out_r_ready
    );
endinterface

// File: rtl/axi4_read_id_arbiter.sv
// Round-robin AXI4 read arbiter: N requesters onto one AR/R port.
// Source index is prepended to the ID; R beats route back on it.
module axi4_read_id_arbiter #(
    parameter int N               = 4,
    parameter int IN_ID_W         = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic clock,
    input  logic reset,
    axi4_read_id_arbiter_if.slave bus,
    output logic busy,
    output logic err_unexpected_r
);
    localparam int SRC_W    = $clog2(N);
    localparam int OUT_ID_W = IN_ID_W + SRC_W;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      locked;
    logic                      lock_take;
    logic [SRC_W-1:0]          lock_idx;
    logic [SRC_W-1:0]          rr_ptr;
    logic [SRC_W-1:0]          rr_sel;
    logic [SRC_W-1:0]          sel;
    logic [SRC_W-1:0]          scan;
    logic [SRC_W-1:0]          src;
    logic                      found;
    logic [N-1:0]              eligible;
    logic                      ar_fire;
    logic                      r_last_fire;
    logic [N-1:0][CNT_W-1:0]   cnt;

    assign locked = (state == LOCKED);
    assign src    = bus.out_r_bits_id[OUT_ID_W-1 -: SRC_W];

    // Eligibility and round-robin pick starting at rr_ptr
    always_comb begin
        eligible = '0;
        rr_sel   = '0;
        found    = 1'b0;
        scan     = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = bus.in_ar_valid[i] &&
                          (cnt[i] < CNT_W'(MAX_OUTSTANDING));
        end
        for (int k = 0; k < N; k++) begin
            scan = rr_ptr + SRC_W'(k);
            if (!found && eligible[scan]) begin
                rr_sel = scan;
                found  = 1'b1;
            end
        end
    end

    // AR mux: a held grant stays on lock_idx until accepted
    always_comb begin
        sel = locked ? lock_idx : rr_sel;
        bus.out_ar_valid = !reset && (locked || (|eligible));
        bus.out_ar_bits_id = {sel,
            bus.in_ar_bits_id[int'(sel)*IN_ID_W +: IN_ID_W]};
        bus.out_ar_bits_addr =
            bus.in_ar_bits_addr[int'(sel)*ADDR_W +: ADDR_W];
        bus.out_ar_bits_len   = bus.in_ar_bits_len[int'(sel)*8 +: 8];
        bus.out_ar_bits_size  = bus.in_ar_bits_size[int'(sel)*3 +: 3];
        bus.out_ar_bits_burst = bus.in_ar_bits_burst[int'(sel)*2 +: 2];
        ar_fire = bus.out_ar_valid && bus.out_ar_ready;
        bus.in_ar_ready = '0;
        if (ar_fire) bus.in_ar_ready[sel] = 1'b1;
    end

    // R demux on the source bits; payload is broadcast
    always_comb begin
        bus.in_r_valid = '0;
        if (!reset && bus.out_r_valid) bus.in_r_valid[src] = 1'b1;
        bus.out_r_ready    = !reset && bus.in_r_ready[src];
        bus.in_r_bits_id   = bus.out_r_bits_id[IN_ID_W-1:0];
        bus.in_r_bits_data = bus.out_r_bits_data;
        bus.in_r_bits_resp = bus.out_r_bits_resp;
        bus.in_r_bits_last = bus.out_r_bits_last;
        r_last_fire = bus.out_r_valid && bus.out_r_ready &&
                      bus.out_r_bits_last;
    end

    // Lock FSM next state: hold a stalled grant until ready
    always_comb begin
        state_next = state;
        lock_take  = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (bus.out_ar_valid && !bus.out_ar_ready) begin
                    state_next = LOCKED;
                    lock_take  = 1'b1;
                end
            end
            LOCKED: begin
                if (bus.out_ar_ready) state_next = UNLOCKED;
            end
            default: state_next = UNLOCKED;
        endcase
    end

    // Busy reflects any in-flight burst in the counter state
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] != '0) busy = 1'b1;
        end
        if (reset) busy = 1'b0;
    end

    // State, pointer, outstanding counters and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= UNLOCKED;
            lock_idx         <= '0;
            rr_ptr           <= '0;
            cnt              <= '0;
            err_unexpected_r <= 1'b0;
        end else begin
            state <= state_next;
            if (lock_take) lock_idx <= sel;
            if (ar_fire)   rr_ptr   <= sel + 1'b1;
            for (int i = 0; i < N; i++) begin
                logic inc;
                logic dec;
                inc = ar_fire && (sel == SRC_W'(i));
                dec = r_last_fire && (src == SRC_W'(i)) &&
                      (cnt[i] != '0);
                if (inc && !dec)      cnt[i] <= cnt[i] + 1'b1;
                else if (dec && !inc) cnt[i] <= cnt[i] - 1'b1;
            end
            if (r_last_fire && (cnt[src] == '0))
                err_unexpected_r <= 1'b1;
        end
    end
endmodule
